game_clock_score: RTL and testbench
===================================

// Module: game_clock_score
// PURPOSE
//  Producer side of the score display interface. It runs the countdown game clock (minutes:seconds)
//  and the point accumulator, and drives the num1/num2/mode/enable inputs of score_display.
//  It sits between game logic (point events, start/pause buttons) and the seven-segment path.
//  Time mode shows mm*100+ss on the display; score mode shows the score as 0..9999.
// PARAMETERS
//  CLK_HZ        100_000_000  clk cycles per game second (prescaler terminal count)
//  GAME_SECONDS  120          round length in seconds; legal range 1..5999 (max 99:59)
// PORTS
//  clk          in   1   system clock; the only clock
//  reset        in   1   synchronous, active-high reset
//  start        in   1   1-cycle pulse: begin a new round (IDLE/OVER only)
//  pause        in   1   1-cycle pulse: toggle RUN<->PAUSED
//  mode_toggle  in   1   1-cycle pulse: flip display mode
//  pts_valid    in   1   1-cycle pulse: add pts to score
//  pts          in   8   points to add (unsigned)
//  num1         out  14  seconds (time mode) or score (score mode)
//  num2         out  7   minutes (time mode) or 0 (score mode)
//  mode         out  1   1=score, 0=time
//  enable       out  1   display enable
//  time_up      out  1   1-cycle pulse when the clock reaches 00:00
// BEHAVIOUR
//  Reset (sync, high): state=IDLE, mm=GAME_SECONDS/60, ss=GAME_SECONDS%60, score=0,
//   mode=0, prescaler=0, num1=ss, num2=mm, enable=0, time_up=0. Reset during any state
//   aborts the round immediately.
//  FSM: IDLE -start-> RUN; RUN -pause-> PAUSED; PAUSED -pause-> RUN; PAUSED -start-> ignored;
//   RUN -final tick-> OVER; OVER -start-> RUN. start in RUN/PAUSED is ignored. pause in IDLE/OVER
//   is ignored. If start and pause arrive in the same cycle in IDLE/OVER, start wins and pause is dropped.
//  start (accepted): load mm:ss from GAME_SECONDS, score=0, prescaler=0, mode unchanged.
//  Prescaler: counts 0..CLK_HZ-1 only in RUN and holds its value in PAUSED. When it wraps
//   (count==CLK_HZ-1), it issues a one-cycle sec_tick.
//  sec_tick: if ss>0 then ss--; else mm--, ss=59. If the result is 00:00, go to OVER in the
//   next state, assert time_up for exactly that one cycle, and force mode=1.
//  Score: pts_valid is honoured only in RUN, including the cycle of the final tick.
//   score = min(score+pts, 9999), using a 15-bit intermediate, so the score saturates and
//   never wraps. pts_valid in IDLE, PAUSED or OVER is ignored.
//  mode_toggle flips mode in any state. On the OVER-entry cycle, the force to 1 takes
//   priority over a simultaneous toggle.
//  Outputs are registered with 1-cycle latency from internal state: num1 = mode ? score : {8'b0,ss};
//   num2 = mode ? 0 : {1'b0,mm}. enable = 0 in IDLE and 1 in RUN/PAUSED/OVER.
//  Widths: mm 7 bit, ss 6 bit, score 14 bit, prescaler $clog2(CLK_HZ) bit.
// TESTING  (CLK_HZ=4, GAME_SECONDS=62)
//  reset high 2 cycles -> num2=1, num1=2, mode=0, enable=0, time_up=0.
//  start; run 4 cycles -> 01:01, then 8 more cycles -> 00:59 (minute borrow).
//  pause after 2 prescaler counts, wait 20 cycles -> time frozen; pause again -> next
//   tick after 2 more cycles (prescaler held).
//  pts=200 pulsed 60 times in RUN -> score saturates at 9999, not 12000 or a wrapped value.
//  pts_valid on the final-tick cycle -> points counted; time_up high for exactly 1 cycle;
//   mode=1; num1=score, num2=0; later pts_valid ignored.
//  start with pause in IDLE -> RUN, not PAUSED; reset mid-RUN -> IDLE reset values next cycle.

Source files
------------

// File: rtl/game_clock_score_if.sv
// Game-event inputs and score_display drive signals for game_clock_score.
// master = game logic / display side, slave = game_clock_score.
interface game_clock_score_if;
    logic        start;
    logic        pause;
    logic        mode_toggle;
    logic        pts_valid;
    logic [7:0]  pts;
    logic [13:0] num1;
    logic [6:0]  num2;
    logic        mode;
    logic        enable;
    logic        time_up;

    modport master (
        output start, pause, mode_toggle, pts_valid, pts,
        input  num1, num2, mode, enable, time_up
    );

    modport slave (
        input  start, pause, mode_toggle, pts_valid, pts,
        output num1, num2, mode, enable, time_up
    );
endinterface

// File: rtl/game_clock_score.sv
// Countdown game clock (mm:ss) and saturating point accumulator.
// Drives num1/num2/mode/enable of score_display.
module game_clock_score #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned GAME_SECONDS = 120
) (
    input logic                clk,
    input logic                reset,
    game_clock_score_if.slave  gcs_io
);
    localparam int unsigned PreW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PreW-1:0] PreMax   = PreW'(CLK_HZ - 1);
    localparam logic [6:0]      MmInit   = 7'(GAME_SECONDS / 60);
    localparam logic [5:0]      SsInit   = 6'(GAME_SECONDS % 60);
    localparam logic [13:0]     ScoreMax = 14'd9999;

    typedef enum logic [1:0] {StIdle, StRun, StPaused, StOver} state_e;

    state_e            state_q, state_d;
    logic [6:0]        mm_q, mm_d;
    logic [5:0]        ss_q, ss_d;
    logic [13:0]       score_q, score_d;
    logic [PreW-1:0]   pre_q, pre_d;
    logic              mode_q, mode_d;
    logic [13:0]       num1_q, num1_d;
    logic [6:0]        num2_q, num2_d;
    logic              enable_q, enable_d;
    logic              time_up_q, time_up_d;
    logic              sec_tick;
    logic [14:0]       sum;

    always_comb begin
        state_d   = state_q;
        mm_d      = mm_q;
        ss_d      = ss_q;
        score_d   = score_q;
        pre_d     = pre_q;
        mode_d    = mode_q ^ gcs_io.mode_toggle;
        time_up_d = 1'b0;
        sum       = {1'b0, score_q} + {7'b0, gcs_io.pts};
        sec_tick  = (state_q == StRun) && (pre_q == PreMax);

        // Outputs follow the current registered state, one cycle behind.
        num1_d    = mode_q ? score_q : {8'b0, ss_q};
        num2_d    = mode_q ? 7'd0 : {1'b0, mm_q};
        enable_d  = (state_q != StIdle);

        unique case (state_q)
            StIdle, StOver: begin
                if (gcs_io.start) begin
                    state_d = StRun;
                    mm_d    = MmInit;
                    ss_d    = SsInit;
                    score_d = '0;
                    pre_d   = '0;
                end
            end
            StRun: begin
                pre_d = sec_tick ? '0 : pre_q + PreW'(1);
                if (gcs_io.pts_valid) begin
                    score_d = (sum > {1'b0, ScoreMax}) ? ScoreMax : sum[13:0];
                end
                if (gcs_io.pause) begin
                    state_d = StPaused;
                end
                if (sec_tick) begin
                    if (ss_q != 6'd0) begin
                        ss_d = ss_q - 6'd1;
                    end else begin
                        mm_d = mm_q - 7'd1;
                        ss_d = 6'd59;
                    end
                    // Reaching 00:00 overrides a same-cycle pause and mode toggle.
                    if (ss_d == 6'd0 && mm_d == 7'd0) begin
                        state_d   = StOver;
                        time_up_d = 1'b1;
                        mode_d    = 1'b1;
                    end
                end
            end
            StPaused: begin
                if (gcs_io.pause) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            mm_q      <= MmInit;
            ss_q      <= SsInit;
            score_q   <= '0;
            pre_q     <= '0;
            mode_q    <= 1'b0;
            num1_q    <= {8'b0, SsInit};
            num2_q    <= MmInit;
            enable_q  <= 1'b0;
            time_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mm_q      <= mm_d;
            ss_q      <= ss_d;
            score_q   <= score_d;
            pre_q     <= pre_d;
            mode_q    <= mode_d;
            num1_q    <= num1_d;
            num2_q    <= num2_d;
            enable_q  <= enable_d;
            time_up_q <= time_up_d;
        end
    end

    assign gcs_io.num1    = num1_q;
    assign gcs_io.num2    = num2_q;
    assign gcs_io.mode    = mode_q;
    assign gcs_io.enable  = enable_q;
    assign gcs_io.time_up = time_up_q;
endmodule

// File: tb/tb_game_clock_score.sv
// Bench for game_clock_score: a seconds-remaining model checked every cycle,
// plus directed literal checks at the interesting moments of a round.
module tb_game_clock_score;
    localparam int CLK_HZ = 4;
    localparam int GS     = 62;

    logic clk;
    logic reset;
    game_clock_score_if bus ();

    game_clock_score #(.CLK_HZ(CLK_HZ), .GAME_SECONDS(GS)) dut (
        .clk    (clk),
        .reset  (reset),
        .gcs_io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 run, 2 paused, 3 over; time kept as total seconds left.
    int phase, rem, score, cnt, nphase;
    bit mmode, nmode, model_ok;
    int e_num1, e_num2;
    bit e_en, e_tu;

    initial model_ok = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            phase = 0; rem = GS; score = 0; cnt = 0; mmode = 1'b0;
            e_num1 = GS % 60; e_num2 = GS / 60; e_en = 1'b0; e_tu = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            e_num1 = mmode ? score : rem % 60;
            e_num2 = mmode ? 0 : rem / 60;
            e_en   = (phase != 0);
            e_tu   = 1'b0;
            nphase = phase;
            nmode  = mmode ^ bus.mode_toggle;
            if (phase == 1) begin
                if (bus.pts_valid) begin
                    score = score + int'(bus.pts);
                    if (score > 9999) score = 9999;
                end
                if (bus.pause) nphase = 2;
                if (cnt == CLK_HZ - 1) begin
                    cnt = 0;
                    rem = rem - 1;
                    if (rem == 0) begin
                        nphase = 3; e_tu = 1'b1; nmode = 1'b1;
                    end
                end else begin
                    cnt = cnt + 1;
                end
            end else if (phase == 2) begin
                if (bus.pause) nphase = 1;
            end else if (bus.start) begin
                nphase = 1; rem = GS; score = 0; cnt = 0;
            end
            phase = nphase;
            mmode = nmode;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("num1", 32'(bus.num1), 32'(e_num1));
            chk("num2", 32'(bus.num2), 32'(e_num2));
            chk("mode", 32'(bus.mode), 32'(mmode));
            chk("enable", 32'(bus.enable), 32'(e_en));
            chk("time_up", 32'(bus.time_up), 32'(e_tu));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.pause = 1'b0; bus.mode_toggle = 1'b0;
        bus.pts_valid = 1'b0; bus.pts = 8'd0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        chk("rst_num2", 32'(bus.num2), 32'd1);
        chk("rst_num1", 32'(bus.num1), 32'd2);
        chk("rst_mode", 32'(bus.mode), 32'd0);
        chk("rst_enable", 32'(bus.enable), 32'd0);
        chk("rst_time_up", 32'(bus.time_up), 32'd0);

        bus.start = 1'b1; step(); bus.start = 1'b0;
        repeat (5) step();
        chk("t_01_01_ss", 32'(bus.num1), 32'd1);
        chk("t_01_01_mm", 32'(bus.num2), 32'd1);
        repeat (8) step();
        chk("borrow_ss", 32'(bus.num1), 32'd59);
        chk("borrow_mm", 32'(bus.num2), 32'd0);

        bus.pause = 1'b1; step(); bus.pause = 1'b0;
        repeat (20) step();
        chk("paused_frozen", 32'(bus.num1), 32'd59);
        bus.pause = 1'b1; step(); bus.pause = 1'b0;
        step(); step();
        chk("resume_no_tick", 32'(bus.num1), 32'd59);
        step();
        chk("resume_tick", 32'(bus.num1), 32'd58);

        bus.pts = 8'd200; bus.pts_valid = 1'b1;
        repeat (60) step();
        bus.pts_valid = 1'b0;
        bus.mode_toggle = 1'b1; step(); bus.mode_toggle = 1'b0;
        step();
        chk("sat_score", 32'(bus.num1), 32'd9999);
        chk("sat_mode", 32'(bus.mode), 32'd1);
        bus.mode_toggle = 1'b1; step(); bus.mode_toggle = 1'b0;

        reset = 1'b1; step(); reset = 1'b0;
        chk("midrst_num1", 32'(bus.num1), 32'd2);
        chk("midrst_num2", 32'(bus.num2), 32'd1);
        chk("midrst_enable", 32'(bus.enable), 32'd0);

        bus.start = 1'b1; bus.pause = 1'b1; step(); idle_inputs();
        repeat (5) step();
        chk("start_wins_ss", 32'(bus.num1), 32'd1);
        chk("start_wins_en", 32'(bus.enable), 32'd1);
        bus.pts = 8'd10; bus.pts_valid = 1'b1; step(); idle_inputs();
        repeat (241) step();
        bus.pts = 8'd7; bus.pts_valid = 1'b1; bus.mode_toggle = 1'b1; step(); idle_inputs();
        chk("final_time_up", 32'(bus.time_up), 32'd1);
        chk("final_mode", 32'(bus.mode), 32'd1);
        step();
        chk("over_time_up", 32'(bus.time_up), 32'd0);
        chk("over_score", 32'(bus.num1), 32'd17);
        chk("over_num2", 32'(bus.num2), 32'd0);
        bus.pts = 8'd50; bus.pts_valid = 1'b1; step(); idle_inputs();
        step(); step();
        chk("over_pts_ignored", 32'(bus.num1), 32'd17);
        chk("over_enable", 32'(bus.enable), 32'd1);

        bus.start = 1'b1; step(); idle_inputs();
        repeat (10) step();
        chk("restart_score", 32'(bus.num1), 32'd0);
        bus.pts = 8'd255; bus.pts_valid = 1'b1; step(); idle_inputs();
        repeat (3) step();
        chk("restart_pts", 32'(bus.num1), 32'd255);

        reset = 1'b1; step(); reset = 1'b0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
